// File: rtl/sccb_write_master_if.sv
// Request/status handshake and pad-side SDA/SCL signals of the SCCB write master.
// master: the write engine itself; slave: the sequencer/pad side that drives it.
// No storage and no flow control here; the engine owns all timing.
interface sccb_write_master_if;
    logic       start;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl;
    logic       sda_oe;
    logic       sda_in;

    modport master (
        input  start, reg_addr, reg_data, sda_in,
        output busy, done, ack_err, scl, sda_oe
    );

    modport slave (
        output start, reg_addr, reg_data, sda_in,
        input  busy, done, ack_err, scl, sda_oe
    );
endinterface

// File: rtl/sccb_write_master.sv
// Single-register SCCB write (dev addr, reg addr, data), paced by edges of i2c_clk; SCCB_ACK_CHECK_EN enables NACK reporting.
// Latency: outputs move 3 ref_clk edges after each i2c_clk edge; done follows 113 ticks after acceptance.
// Backpressure: start is only sampled in IDLE and never queued; a frozen i2c_clk freezes the bus.
module sccb_write_master #(
    parameter logic [7:0] DEV_ADDR = 8'h42
) (
    input  logic                  ref_clk,
    input  logic                  rst_n,
    input  logic                  i2c_clk,
    sccb_write_master_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BITS,
        S_STOP,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'd26;

    // sync_q[1:0] is the synchronizer, sync_q[2] the history flop for edge detection.
    logic [2:0]  sync_q;
    logic        tick;

    state_t      state_q;
    logic [1:0]  qtr_q;
    logic [4:0]  bit_q;
    logic [26:0] frame_q;
    logic        scl_q;
    logic        sda_oe_q;
    logic        busy_q;
    logic        done_q;
    logic        is_ack_d;
`ifdef SCCB_ACK_CHECK_EN
    logic        ack_err_q;
`endif

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], i2c_clk};
        end
    end

    assign tick     = sync_q[1] ^ sync_q[2];
    assign is_ack_d = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == LAST_BIT);

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            qtr_q     <= 2'd0;
            bit_q     <= 5'd0;
            frame_q   <= '0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
            ack_err_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_START;
                        // Ack slots carry 1 so the q0 drive releases SDA for the slave.
                        frame_q <= {DEV_ADDR[7:1], 1'b0, 1'b1,
                                    bus.reg_addr, 1'b1,
                                    bus.reg_data, 1'b1};
                        qtr_q   <= 2'd0;
                        bit_q   <= 5'd0;
                        busy_q  <= 1'b1;
`ifdef SCCB_ACK_CHECK_EN
                        ack_err_q <= 1'b0;
`endif
                    end
                end

                S_START: begin
                    if (tick) begin
                        if (qtr_q == 2'd0) begin
                            sda_oe_q <= 1'b1;
                            qtr_q    <= 2'd1;
                        end else begin
                            scl_q   <= 1'b0;
                            qtr_q   <= 2'd0;
                            state_q <= S_BITS;
                        end
                    end
                end

                S_BITS: begin
                    if (tick) begin
                        qtr_q <= qtr_q + 2'd1;
                        case (qtr_q)
                            2'd0: sda_oe_q <= ~frame_q[26];
                            2'd1: scl_q    <= 1'b1;
`ifdef SCCB_ACK_CHECK_EN
                            2'd2: begin
                                if (is_ack_d) begin
                                    ack_err_q <= ack_err_q | bus.sda_in;
                                end
                            end
`endif
                            2'd3: begin
                                scl_q   <= 1'b0;
                                frame_q <= {frame_q[25:0], 1'b0};
                                if (bit_q == LAST_BIT) begin
                                    state_q <= S_STOP;
                                end else begin
                                    bit_q <= bit_q + 5'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        case (qtr_q)
                            2'd0: begin
                                sda_oe_q <= 1'b1;
                                qtr_q    <= 2'd1;
                            end
                            2'd1: begin
                                scl_q <= 1'b1;
                                qtr_q <= 2'd2;
                            end
                            default: begin
                                sda_oe_q <= 1'b0;
                                qtr_q    <= 2'd0;
                                state_q  <= S_DONE;
                                done_q   <= 1'b1;
                            end
                        endcase
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Only is_ack_d's consumer differs between builds; keep it referenced in both.
`ifdef SCCB_ACK_CHECK_EN
    assign bus.ack_err = ack_err_q;
`else
    assign bus.ack_err = 1'b0 & is_ack_d;
`endif

    assign bus.scl    = scl_q;
    assign bus.sda_oe = sda_oe_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_sccb_write_master.sv
// Directed bench: bus decode, tick counting, handshake, mid-transaction reset and divider stall.
module tb_sccb_write_master;
    logic ref_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic i2c_clk = 1'b0;
    logic slave_pull = 1'b0;

    sccb_write_master_if bus ();

    // Open-drain wire: low if either side pulls.
    assign bus.sda_in = ~(bus.sda_oe | slave_pull);

    sccb_write_master dut (
        .ref_clk (ref_clk),
        .rst_n   (rst_n),
        .i2c_clk (i2c_clk),
        .bus     (bus.master)
    );

    always #5 ref_clk = ~ref_clk;

    int checks = 0;
    int errors = 0;
    int ticks  = 0;
    int div    = 0;
    int ticks_at_done, done_cnt, nbytes;
    bit start_seen, stop_seen, timed_out, stall_ok, aborted;
    logic       ack_err_at_done;
    logic [2:0] acks;
    logic [7:0] got [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_step();
        div++;
        if (div == 4) begin
            div = 0;
            i2c_clk = ~i2c_clk;
            ticks++;
        end
    endtask

    task automatic start_txn(input logic [7:0] ra, input logic [7:0] rd);
        @(negedge ref_clk);
        bus.start    = 1'b1;
        bus.reg_addr = ra;
        bus.reg_data = rd;
        @(negedge ref_clk);
        bus.start = 1'b0;
        chk("busy_after_accept", {bus.busy, bus.done}, 2'b10);
        ticks = 0;
        div   = 0;
    endtask

    task automatic run_txn(input bit ack_mode, input int stall_bit, input int reset_bit,
                           input int poke_bit, input bit done_poke, input bit chain,
                           input logic [7:0] nra, input logic [7:0] nrd);
        logic prev_scl, prev_oe, s_scl, s_oe, s_busy;
        logic [7:0] shreg;
        int nbit, bits;
        bit poked, stalled;
        done_cnt = 0; nbytes = 0; start_seen = 0; stop_seen = 0;
        timed_out = 1; stall_ok = 1; aborted = 0; acks = 3'b000;
        shreg = 8'h00; nbit = 0; bits = 0; poked = 0; stalled = 0; slave_pull = 1'b0;
        prev_scl = bus.scl;
        prev_oe  = bus.sda_oe;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge ref_clk);
            bus.start = 1'b0;
            if (bus.scl && prev_scl && bus.sda_oe && !prev_oe) begin
                start_seen = 1; bits = 0; nbit = 0;
            end else if (bus.scl && prev_scl && !bus.sda_oe && prev_oe) begin
                stop_seen = 1;
            end else if (bus.scl && !prev_scl) begin
                if (nbit < 8) begin
                    shreg = {shreg[6:0], bus.sda_in};
                    nbit++;
                end else begin
                    if (nbytes < 3) begin
                        got[nbytes[1:0]]  = shreg;
                        acks[nbytes[1:0]] = bus.sda_in;
                    end
                    nbytes++;
                    nbit = 0;
                end
                bits++;
            end else if (!bus.scl && prev_scl) begin
                slave_pull = ack_mode && (nbit == 8);
            end
            prev_scl = bus.scl;
            prev_oe  = bus.sda_oe;

            if (bus.done === 1'b1) begin
                done_cnt++;
                ack_err_at_done = bus.ack_err;
                ticks_at_done   = ticks;
                timed_out       = 0;
                break;
            end
            if (reset_bit >= 0 && bits == reset_bit && !bus.scl && bus.sda_oe) begin
                #2 rst_n = 1'b0;
                #1;
                chk("midreset_release", {bus.scl, bus.sda_oe, bus.busy, bus.done}, 4'b1000);
                timed_out = 0; aborted = 1; slave_pull = 1'b0;
                repeat (3) @(negedge ref_clk);
                rst_n = 1'b1;
                break;
            end
            if (poke_bit >= 0 && bits == poke_bit && !poked) begin
                bus.start = 1'b1;
                poked = 1;
            end
            if (stall_bit >= 0 && bits == stall_bit && bus.scl && !stalled) begin
                stalled = 1;
                s_scl = bus.scl; s_oe = bus.sda_oe; s_busy = bus.busy;
                repeat (10000) begin
                    @(negedge ref_clk);
                    if (bus.scl !== s_scl || bus.sda_oe !== s_oe ||
                        bus.busy !== s_busy || bus.done !== 1'b0)
                        stall_ok = 0;
                end
            end
            i2c_step();
        end
        if (aborted || timed_out) return;
        if (done_poke) begin
            bus.start = 1'b1;
            @(negedge ref_clk);
            bus.start = 1'b0;
            chk("busy_done_fall", {bus.busy, bus.done}, 2'b00);
            repeat (3) begin
                @(negedge ref_clk);
                chk("start_in_done_ignored", {bus.busy, bus.done}, 2'b00);
            end
        end else if (chain) begin
            @(negedge ref_clk);
            chk("busy_done_fall", {bus.busy, bus.done}, 2'b00);
            bus.start    = 1'b1;
            bus.reg_addr = nra;
            bus.reg_data = nrd;
            @(negedge ref_clk);
            bus.start = 1'b0;
            chk("busy_after_chain_accept", bus.busy, 1'b1);
            ticks = 0;
            div   = 0;
        end else begin
            repeat (6) begin
                @(negedge ref_clk);
                if (bus.done === 1'b1) done_cnt++;
            end
        end
    endtask

    task automatic verify(input logic [7:0] ra, input logic [7:0] rd,
                          input logic exp_err, input logic [2:0] exp_acks);
        chk("txn_timeout", timed_out, 1'b0);
        chk("start_cond", start_seen, 1'b1);
        chk("stop_cond", stop_seen, 1'b1);
        chk("byte_count", nbytes, 3);
        chk("dev_addr_byte", got[0], 8'h42);
        chk("reg_addr_byte", got[1], ra);
        chk("reg_data_byte", got[2], rd);
        chk("ack_bits", acks, exp_acks);
        chk("tick_count", ticks_at_done, 113);
        chk("done_pulses", done_cnt, 1);
        chk("ack_err", ack_err_at_done, exp_err);
    endtask

    initial begin
        logic nack_err;
`ifdef SCCB_ACK_CHECK_EN
        nack_err = 1'b1;
`else
        nack_err = 1'b0;
`endif
        bus.start    = 1'b0;
        bus.reg_addr = 8'h00;
        bus.reg_data = 8'h00;

        // Reset held while the divider keeps running.
        repeat (20) begin
            @(negedge ref_clk);
            i2c_clk = ~i2c_clk;
            chk("reset_outputs", {bus.scl, bus.sda_oe, bus.busy, bus.done, bus.ack_err}, 5'b10000);
        end
        rst_n = 1'b1;
        repeat (6) @(negedge ref_clk);
        chk("idle_after_reset", {bus.scl, bus.sda_oe, bus.busy, bus.done, bus.ack_err}, 5'b10000);

        // Nominal write with slave acks.
        start_txn(8'h12, 8'h80);
        run_txn(1, -1, -1, -1, 0, 0, 8'h00, 8'h00);
        verify(8'h12, 8'h80, 1'b0, 3'b000);

        // Slave never acks: all bytes still go out.
        start_txn(8'h5A, 8'hA5);
        run_txn(0, -1, -1, -1, 0, 0, 8'h00, 8'h00);
        verify(8'h5A, 8'hA5, nack_err, 3'b111);

        // Start pulses in byte 1 and in the DONE cycle are ignored.
        start_txn(8'h33, 8'hCC);
        run_txn(1, -1, -1, 3, 1, 0, 8'h00, 8'h00);
        verify(8'h33, 8'hCC, 1'b0, 3'b000);

        // Start in the cycle right after DONE is accepted.
        start_txn(8'h01, 8'h02);
        run_txn(1, -1, -1, -1, 0, 1, 8'h7E, 8'h81);
        verify(8'h01, 8'h02, 1'b0, 3'b000);
        run_txn(1, -1, -1, -1, 0, 0, 8'h00, 8'h00);
        verify(8'h7E, 8'h81, 1'b0, 3'b000);

        // Reset during bit 15 (reg_addr bit 1 = 0 drives SDA low there).
        start_txn(8'h04, 8'h99);
        run_txn(1, -1, 15, -1, 0, 0, 8'h00, 8'h00);
        chk("midreset_reached", aborted, 1'b1);
        repeat (6) @(negedge ref_clk);
        chk("idle_after_midreset", {bus.scl, bus.sda_oe, bus.busy, bus.done}, 4'b1000);
        start_txn(8'h12, 8'h80);
        run_txn(1, -1, -1, -1, 0, 0, 8'h00, 8'h00);
        verify(8'h12, 8'h80, 1'b0, 3'b000);

        // Divider frozen mid reg_addr byte.
        start_txn(8'hC3, 8'h3C);
        run_txn(1, 12, -1, -1, 0, 0, 8'h00, 8'h00);
        chk("stall_hold", stall_ok, 1'b1);
        verify(8'hC3, 8'h3C, 1'b0, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
